// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one full-adder step per clock, LSB first
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (op_a, op_b, op_sub: 0 = A+B, 1 = A-B)
//   out_valid / out_ready result handshake (sum, cout, ovf held while out_valid)
//   cout                  final carry; on subtract 1 means no borrow
//   ovf                   two's-complement signed overflow
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, ovf_q, out_valid_q;
    logic             s, c;

    assign s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign c     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign res_d = {s, res_q[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    // subtraction is A + ~B + 1: invert B here, the +1 is the initial carry
                    a_q     <= op_a;
                    b_q     <= op_sub ? ~op_b : op_b;
                    carry_q <= op_sub;
                    cnt_q   <= '0;
                    res_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // MSB step: signed overflow is carry-in xor carry-out of this bit
                        sum_q       <= res_d;
                        cout_q      <= c;
                        ovf_q       <= carry_q ^ c;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed self-checking bench for serial_addsub (WIDTH=8)
module tb_serial_addsub;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, op_sub, out_valid, out_ready, cout, ovf;
    logic [7:0] op_a, op_b, sum;
    int         checks = 0;
    int         errors = 0;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
        int lat;
        check({tag, "_rdy"}, in_ready, 1);
        op_a = a; op_b = b; op_sub = s; in_valid = 1;
        step;
        in_valid = 0; op_a = 8'h00; op_b = 8'h00; op_sub = 0;
        check({tag, "_run_rdy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step;
            lat++;
        end
        check({tag, "_lat"}, lat, 8);
    endtask

    task automatic drain(input string tag);
        out_ready = 1;
        step;
        out_ready = 0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
        run_op(a, b, s, tag);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        drain(tag);
    endtask

    initial begin
        int acc_t[2];
        logic [7:0] res[2];
        int nacc, nres, k;
        rst = 1; in_valid = 0; out_ready = 0; op_a = 0; op_b = 0; op_sub = 0;
        step;
        step;
        check("rst_rdy", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check("rst_sum", sum, 0);
        rst = 0;
        #1;
        check("post_rst_rdy", in_ready, 1);

        op(8'h35, 8'h1A, 0, 8'h4F, 0, 0, "add1");
        op(8'h7F, 8'h01, 0, 8'h80, 0, 1, "add_ovf");
        op(8'hFF, 8'h01, 0, 8'h00, 1, 0, "add_wrap");
        op(8'h05, 8'h07, 1, 8'hFE, 0, 0, "sub_borrow");
        op(8'h80, 8'h01, 1, 8'h7F, 1, 1, "sub_ovf");

        run_op(8'h35, 8'h1A, 0, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; op_a = 8'h11; op_b = 8'h22;
            check("bp_vld", out_valid, 1);
            check("bp_sum", sum, 8'h4F);
            check("bp_cout", cout, 0);
            check("bp_rdy", in_ready, 0);
            step;
        end
        in_valid = 0;
        drain("bp");
        step;
        check("bp_no_accept", in_ready, 1);

        op_a = 8'hAA; op_b = 8'h55; op_sub = 0; in_valid = 1;
        step;
        in_valid = 0;
        step; step; step;
        rst = 1;
        #1;
        check("mid_rst_rdy", in_ready, 0);
        step;
        rst = 0;
        #1;
        check("mid_rst_vld", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_rdy1", in_ready, 1);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) k++;
            step;
        end
        check("mid_rst_never", k, 0);
        op(8'h01, 8'h01, 0, 8'h02, 0, 0, "after_rst");

        nacc = 0; nres = 0;
        out_ready = 1; in_valid = 1; op_a = 8'h10; op_b = 8'h20; op_sub = 0;
        for (int i = 0; i < 40 && nres < 2; i++) begin
            if (nacc == 1) begin op_a = 8'hC8; op_b = 8'h64; op_sub = 1; end
            if (nacc == 2) in_valid = 0;
            if (in_ready && in_valid && nacc < 2) begin acc_t[nacc] = i; nacc++; end
            if (out_valid && nres < 2) begin res[nres] = sum; nres++; end
            step;
        end
        in_valid = 0; out_ready = 0;
        check("b2b_nacc", nacc, 2);
        check("b2b_nres", nres, 2);
        if (nacc == 2) check("b2b_gap", acc_t[1] - acc_t[0], 10);
        if (nres == 2) begin
            check("b2b_res0", res[0], 8'h30);
            check("b2b_res1", res[1], 8'h64);
        end
        check("b2b_cout", cout, 1);
        check("b2b_ovf", ovf, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
